mmio_responder: RTL and testbench
=================================

// Module: mmio_responder
// PURPOSE
//  Memory-bus responder for the CPU's memory-mapped I/O window: decodes the CPU's address/read/write
//  strobes, returns read data to the CPU bus and applies register side effects. Provides an output
//  port latch, an 8-deep receive FIFO fed by an external byte source, and a prescaled down-timer.
//  Sits beside RAM/ROM in the top level; the top-level read mux selects rdata when sel=1.
// PARAMETERS
//  MMIO_BASE  16'hFF00  base of 16-byte window; decode compares cpu_addr[ADDR_WIDTH-1:4]
//  RX_DEPTH   8         receive FIFO depth, power of 2, >=2
//  PRESCALE   1000      clk cycles per timer tick, >=1
// PORTS
//  clk          in   1           system clock
//  reset        in   1           async, active-high
//  cpu_addr     in   ADDR_WIDTH  CPU mem_address
//  cpu_read     in   1           CPU mem_read strobe
//  cpu_write    in   1           CPU mem_write strobe
//  cpu_wdata    in   DATA_WIDTH  CPU mem_data_out
//  rdata        out  DATA_WIDTH  read data to CPU (combinational); 0 when not selected
//  sel          out  1           cpu_addr inside window (combinational)
//  rx_data      in   8           external byte
//  rx_valid     in   1           rx_data valid
//  rx_ready     out  1           = !fifo_full
//  port_out     out  8           OUT_PORT register
//  timer_flag   out  1           STATUS.timer_flag
// BEHAVIOUR
//  Clock and reset: one clock, clk; reset is asynchronous and active-high. Reset clears port_out,
//   FIFO (empty, rx_ready=1), overflow, timer_flag, RELOAD, CTRL, COUNT and the prescaler.
//  Bus timing:
//   - rdata is combinational from cpu_addr and current state, valid in the same cycle as cpu_read.
//   - Side effects (pop, write) commit at the rising edge ending a cycle with sel and the strobe.
//   - The CPU guarantees single-cycle strobes; every strobed cycle is one access.
//   - cpu_read&&cpu_write together: write performed, read side effects suppressed.
//  Register map (offset):
//   0 OUT_PORT   R/W  write latches port_out; read returns it
//   1 STATUS     R    [0]rx_not_empty [1]rx_full [2]rx_overflow(sticky) [3]timer_flag; [7:4]=0
//                W1C  writing 1 to bit 2/3 clears it. A set event in the same cycle wins over the clear.
//   2 RX_DATA    R    FIFO head; a read pops when non-empty. A read when empty returns 8'h00, no pop. W ignored.
//   3 RELOAD     R/W  write sets RELOAD and COUNT to wdata and zeroes the prescaler
//   4 CTRL       R/W  [0]enable [1]auto_reload; [7:2] read 0
//   5 COUNT      R    current count
//   6-F          read 8'h00, writes ignored
//  RX FIFO (RX_DEPTH):
//   - Pushes on rx_valid&&rx_ready.
//   - rx_valid while full: byte dropped and rx_overflow set.
//   - Pop and push in the same cycle: both occur, occupancy unchanged. The empty-read rule still applies.
//   - Pointers wrap modulo RX_DEPTH; occupancy counter is $clog2(RX_DEPTH)+1 bits.
//  Timer:
//   - When CTRL.enable=1, the prescaler counts 0..PRESCALE-1; at terminal count it wraps and emits a tick.
//   - On a tick with COUNT!=0: COUNT decrements.
//   - On a tick with COUNT==0: timer_flag set; COUNT<=RELOAD if auto_reload, else CTRL.enable cleared.
//   - CTRL.enable=0: prescaler held at 0, COUNT frozen.
//   - A RELOAD/CTRL write in a tick cycle takes priority over the tick's COUNT/enable update.
//  Width: 8-bit counters wrap only via reload, never below 0. Unselected writes are ignored.
//  Reset mid-operation: all state returns to the reset values above immediately (async).
// STRUCTURE
//  Shared package (arch_defs_pkg):
//   - MMIO_BASE default, register offset enum mmio_reg_e
//   - STATUS bit indices, CTRL bit indices
//  Sub-module: sync_fifo #(WIDTH=8, DEPTH=RX_DEPTH) — push/pop/full/empty/head, async active-high reset.
//  Top: decode, register file, W1C/sticky logic, timer FSM (IDLE/RUN, enable bit is the state).
// TESTING
//  1 Write 0x5A @FF00, read @FF00 -> port_out=0x5A, rdata=0x5A; write @FF10 -> sel=0, port_out unchanged.
//  2 Push 0x11,0x22 -> STATUS=0x01; read FF02 twice -> 0x11 then 0x22; third read -> 0x00, STATUS=0x00.
//  3 Push 9 bytes (DEPTH=8) -> rx_ready=0 after 8th, STATUS=0x07. Write 0x04 to FF01 -> STATUS=0x03.
//    Drain -> the 8 first bytes in order.
//  4 PRESCALE=4, RELOAD=2, CTRL=0x03 -> timer_flag rises 12 clks after CTRL write (ticks at 4,8,12).
//    COUNT reads 2 after the tick, reflag at 24.
//  5 One-shot: CTRL=0x01, RELOAD=0 -> flag at first tick, CTRL reads 0x00. W1C 0x08 clears the flag.
//    The flag does not re-set.
//  6 Assert reset mid-countdown with FIFO non-empty -> all outputs/registers zero; rx_ready=1 with no clock edge.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// Shared definitions for the MMIO window: the default base address,
// the register offsets, the STATUS/CTRL bit positions and the timer states.
package arch_defs_pkg;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hFF00;

    typedef enum logic [3:0] {
        REG_OUT_PORT = 4'h0,
        REG_STATUS   = 4'h1,
        REG_RX_DATA  = 4'h2,
        REG_RELOAD   = 4'h3,
        REG_CTRL     = 4'h4,
        REG_COUNT    = 4'h5
    } mmio_reg_e;

    localparam int STATUS_RX_NOT_EMPTY = 0;
    localparam int STATUS_RX_FULL      = 1;
    localparam int STATUS_RX_OVERFLOW  = 2;
    localparam int STATUS_TIMER_FLAG   = 3;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/mmio_responder_if.sv
// CPU memory-bus signals seen by the MMIO responder; the CPU side is the
// master, the responder is the slave.
interface mmio_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_read;
    logic                  cpu_write;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  sel;

    modport master (
        output cpu_addr, cpu_read, cpu_write, cpu_wdata,
        input  rdata, sel
    );

    modport slave (
        input  cpu_addr, cpu_read, cpu_write, cpu_wdata,
        output rdata, sel
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. Pushes when full and pops
// when empty are ignored, so callers may present raw requests.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array is deliberately left out of reset; validity is
    // carried entirely by the pointers and the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: address decode, output port, RX FIFO with sticky overflow,
// and a prescaled down-timer whose run/idle state is the CTRL.enable bit.
module mmio_responder
    import arch_defs_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = ADDR_WIDTH'(MMIO_BASE_DEFAULT),
    parameter int                    RX_DEPTH   = 8,
    parameter int                    PRESCALE   = 1000
) (
    input  logic             clk,
    input  logic             reset,
    mmio_responder_if.slave  bus,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       port_out,
    output logic             timer_flag
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    mmio_reg_e    offset;
    logic         wr_en;
    logic         rd_en;
    logic [7:0]   port_out_q;
    logic [7:0]   reload_q;
    logic         auto_reload_q;
    logic         overflow_q;
    logic         flag_q;
    logic         overflow_d;
    logic         flag_d;
    timer_state_e state_q;
    timer_state_e state_d;
    logic [7:0]   count_q;
    logic [7:0]   count_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic         tick;
    logic         flag_set;
    logic         status_w1c;
    logic         fifo_pop;
    logic [7:0]   fifo_head;
    logic         fifo_full;
    logic         fifo_empty;

    assign bus.sel = (bus.cpu_addr[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4]);
    assign offset  = mmio_reg_e'(bus.cpu_addr[3:0]);
    // A simultaneous write wins: the read still returns data but has no side effect.
    assign wr_en   = bus.sel && bus.cpu_write;
    assign rd_en   = bus.sel && bus.cpu_read && !bus.cpu_write;

    assign fifo_pop   = rd_en && (offset == REG_RX_DATA);
    assign status_w1c = wr_en && (offset == REG_STATUS);

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid),
        .pop   (fifo_pop),
        .din   (rx_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tick = (state_q == T_RUN) && (presc_q == PW'(PRESCALE - 1));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        presc_d  = '0;
        flag_set = 1'b0;
        if (state_q == T_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                if (count_q != 8'h00) begin
                    count_d = count_q - 8'h01;
                end else begin
                    flag_set = 1'b1;
                    if (auto_reload_q) count_d = reload_q;
                    else               state_d = T_IDLE;
                end
            end
        end
        // Register writes override whatever the tick decided this cycle.
        if (wr_en && offset == REG_RELOAD) begin
            count_d = bus.cpu_wdata;
            presc_d = '0;
        end
        if (wr_en && offset == REG_CTRL)
            state_d = bus.cpu_wdata[CTRL_ENABLE] ? T_RUN : T_IDLE;
        if (state_d == T_IDLE) presc_d = '0;

        // Sticky bits: a set event in the same cycle beats the W1C clear.
        overflow_d = (rx_valid && fifo_full) ||
                     (overflow_q && !(status_w1c && bus.cpu_wdata[STATUS_RX_OVERFLOW]));
        flag_d     = flag_set ||
                     (flag_q && !(status_w1c && bus.cpu_wdata[STATUS_TIMER_FLAG]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= T_IDLE;
            count_q <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_out_q    <= '0;
            reload_q      <= '0;
            auto_reload_q <= 1'b0;
            overflow_q    <= 1'b0;
            flag_q        <= 1'b0;
        end else begin
            if (wr_en && offset == REG_OUT_PORT) port_out_q <= bus.cpu_wdata;
            if (wr_en && offset == REG_RELOAD)   reload_q   <= bus.cpu_wdata;
            if (wr_en && offset == REG_CTRL)     auto_reload_q <= bus.cpu_wdata[CTRL_AUTO_RELOAD];
            overflow_q <= overflow_d;
            flag_q     <= flag_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (offset)
                REG_OUT_PORT: bus.rdata = port_out_q;
                REG_STATUS:   bus.rdata = {4'b0000, flag_q, overflow_q, fifo_full, !fifo_empty};
                REG_RX_DATA:  bus.rdata = fifo_empty ? 8'h00 : fifo_head;
                REG_RELOAD:   bus.rdata = reload_q;
                REG_CTRL:     bus.rdata = {6'b000000, auto_reload_q, state_q == T_RUN};
                REG_COUNT:    bus.rdata = count_q;
                default:      bus.rdata = '0;
            endcase
        end
    end

    assign rx_ready   = !fifo_full;
    assign port_out   = port_out_q;
    assign timer_flag = flag_q;
endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: bus reads are scored against a
// queue of expectations filled by the driver and drained by a read monitor.
module tb_mmio_responder;
    import arch_defs_pkg::*;

    localparam int PRESCALE = 4;
    localparam int RX_DEPTH = 8;

    typedef struct {
        string      tag;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] port_out;
    logic       timer_flag;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         t0;
    logic       rd_active = 1'b0;
    exp_t       exp_q[$];
    logic [7:0] rx_model[$];
    logic       ovf_exp = 1'b0;
    logic       flag_exp = 1'b0;

    mmio_responder_if bus ();

    mmio_responder #(.PRESCALE(PRESCALE), .RX_DEPTH(RX_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .port_out   (port_out),
        .timer_flag (timer_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Read monitor: scores rdata in every cycle the driver holds a read.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rd_active) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(e.tag, bus.rdata, e.data);
                end
            end
        end
    end

    function automatic logic [7:0] status_exp();
        return {4'b0000, flag_exp, ovf_exp, rx_model.size() == RX_DEPTH, rx_model.size() != 0};
    endfunction

    function automatic logic [7:0] rx_pop_exp();
        if (rx_model.size() == 0) return 8'h00;
        return rx_model.pop_front();
    endfunction

    task automatic expect_read(input string tag, input logic [7:0] data);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic bus_read(input logic [15:0] addr, input string tag, input logic [7:0] data);
        expect_read(tag, data);
        bus.cpu_addr = addr;
        bus.cpu_read = 1'b1;
        rd_active    = 1'b1;
        @(negedge clk);
        bus.cpu_read = 1'b0;
        rd_active    = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        bus.cpu_addr  = addr;
        bus.cpu_wdata = data;
        bus.cpu_write = 1'b1;
        @(negedge clk);
        bus.cpu_write = 1'b0;
    endtask

    task automatic bus_read_write(input logic [15:0] addr, input logic [7:0] wdata,
                                  input string tag, input logic [7:0] data);
        expect_read(tag, data);
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_read  = 1'b1;
        bus.cpu_write = 1'b1;
        rd_active     = 1'b1;
        @(negedge clk);
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        rd_active     = 1'b0;
    endtask

    task automatic model_push(input logic [7:0] b, input logic was_full);
        if (was_full) ovf_exp = 1'b1;
        else          rx_model.push_back(b);
    endtask

    task automatic rx_push(input logic [7:0] b);
        model_push(b, rx_model.size() == RX_DEPTH);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // RX_DATA pop and an incoming byte in the same cycle.
    task automatic read_rx_with_push(input logic [7:0] b, input string tag);
        logic       was_full;
        logic [7:0] head;
        was_full = (rx_model.size() == RX_DEPTH);
        head     = rx_pop_exp();
        model_push(b, was_full);
        rx_data  = b;
        rx_valid = 1'b1;
        bus_read(16'hFF02, tag, head);
        rx_valid = 1'b0;
    endtask

    task automatic wait_flag();
        for (int i = 0; i < 64 && !timer_flag; i++) @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_port_out", port_out, 8'h00);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_timer_flag", timer_flag, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        bus_read(16'hFF01, "rst_status", 8'h00);
        bus_read(16'hFF05, "rst_count", 8'h00);
        bus_read(16'hFF04, "rst_ctrl", 8'h00);

        // Output port and decode boundaries
        bus_write(16'hFF00, 8'h5A);
        check("port_out_write", port_out, 8'h5A);
        bus_read(16'hFF00, "out_port_read", 8'h5A);
        bus.cpu_addr  = 16'hFF10;
        bus.cpu_wdata = 8'hA5;
        bus.cpu_write = 1'b1;
        #1;
        check("sel_outside", bus.sel, 1'b0);
        @(negedge clk);
        bus.cpu_write = 1'b0;
        check("port_out_unsel", port_out, 8'h5A);
        bus_read(16'hFF10, "rd_outside", 8'h00);
        bus_read(16'hFEFF, "rd_below", 8'h00);
        bus_write(16'hFF09, 8'h77);
        bus_read(16'hFF09, "rd_reserved", 8'h00);

        // RX FIFO basics, empty read, read+write and pop+push
        rx_push(8'h11);
        rx_push(8'h22);
        bus_read(16'hFF01, "status_two", status_exp());
        bus_read(16'hFF02, "rx_first", rx_pop_exp());
        bus_read(16'hFF02, "rx_second", rx_pop_exp());
        bus_read(16'hFF02, "rx_empty", rx_pop_exp());
        bus_read(16'hFF01, "status_empty", status_exp());
        rx_push(8'h66);
        bus_read_write(16'hFF02, 8'hFF, "rx_rw_nopop", rx_model[0]);
        bus_read(16'hFF01, "status_after_rw", status_exp());
        read_rx_with_push(8'h77, "rx_pop_push");
        bus_read(16'hFF01, "status_pop_push", status_exp());
        bus_read(16'hFF02, "rx_after_pp", rx_pop_exp());

        // Overflow, W1C of the sticky bit, drain in order
        for (int i = 0; i < RX_DEPTH + 1; i++) begin
            rx_push(8'h80 + 8'(i));
            if (i == RX_DEPTH - 2) check("rx_ready_7", rx_ready, 1'b1);
            if (i == RX_DEPTH - 1) check("rx_ready_8", rx_ready, 1'b0);
        end
        bus_read(16'hFF01, "status_ovf", status_exp());
        bus_write(16'hFF01, 8'h04);
        ovf_exp = 1'b0;
        bus_read(16'hFF01, "status_w1c_ovf", status_exp());
        for (int i = 0; i < RX_DEPTH; i++) bus_read(16'hFF02, "rx_drain", rx_pop_exp());
        bus_read(16'hFF01, "status_drained", status_exp());

        // Auto-reload timer
        bus_write(16'hFF03, 8'h02);
        bus_write(16'hFF04, 8'h03);
        t0 = cyc;
        wait_flag();
        check("flag_first_cyc", cyc - t0, 12);
        flag_exp = 1'b1;
        bus_read(16'hFF05, "count_reloaded", 8'h02);
        bus_read(16'hFF01, "status_flag", status_exp());
        bus_write(16'hFF01, 8'h08);
        flag_exp = 1'b0;
        check("flag_w1c", timer_flag, 1'b0);
        wait_flag();
        check("flag_second_cyc", cyc - t0, 24);
        bus_write(16'hFF04, 8'h00);
        bus_write(16'hFF01, 8'h08);

        // One-shot timer
        bus_write(16'hFF03, 8'h00);
        bus_write(16'hFF04, 8'h01);
        t0 = cyc;
        wait_flag();
        check("oneshot_cyc", cyc - t0, 4);
        flag_exp = 1'b1;
        bus_read(16'hFF04, "ctrl_oneshot", 8'h00);
        bus_read(16'hFF01, "status_oneshot", status_exp());
        bus_write(16'hFF01, 8'h08);
        flag_exp = 1'b0;
        repeat (20) @(negedge clk);
        check("oneshot_no_reflag", timer_flag, 1'b0);

        // Asynchronous reset mid-countdown with FIFO occupied
        bus_write(16'hFF00, 8'hC3);
        bus_write(16'hFF03, 8'h50);
        bus_write(16'hFF04, 8'h01);
        rx_push(8'h9A);
        rx_push(8'h9B);
        repeat (6) @(negedge clk);
        bus_read(16'hFF05, "count_mid", 8'h4E);
        #1 reset = 1'b1;
        #1;
        check("async_port_out", port_out, 8'h00);
        check("async_rx_ready", rx_ready, 1'b1);
        check("async_flag", timer_flag, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        rx_model.delete();
        ovf_exp  = 1'b0;
        flag_exp = 1'b0;
        bus_read(16'hFF01, "post_rst_status", status_exp());
        bus_read(16'hFF02, "post_rst_rx", 8'h00);
        bus_read(16'hFF03, "post_rst_reload", 8'h00);
        bus_read(16'hFF04, "post_rst_ctrl", 8'h00);
        bus_read(16'hFF05, "post_rst_count", 8'h00);
        bus_read(16'hFF00, "post_rst_out", 8'h00);

        @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
